// File: rtl/disp_vramrd_ctrl_if.sv
// ---------------------------------------------------------------------------
// disp_vramrd_ctrl_if
//   Bus bundle between the display VRAM read sequencer, the memory read port
//   and the display FIFO write side.
//
//   master : the read sequencer (drives AR request, RREADY and FIFO writes)
//   slave  : memory / FIFO side (drives ARREADY, R data channel, fill level)
//
//   ARADDR    [31:0]  read burst byte address
//   ARLEN     [7:0]   burst length - 1
//   ARVALID/ARREADY   read address handshake
//   RDATA     [63:0]  read data beat
//   RVALID/RREADY     read data handshake, RLAST marks the final beat
//   BUF_WREN          FIFO write strobe
//   BUF_WDATA [63:0]  FIFO write data
//   BUF_WRCNT [CW-1:0] FIFO fill level in 64-bit words
// ---------------------------------------------------------------------------
interface disp_vramrd_ctrl_if #(
  parameter int CW = 10
);
  logic [31:0]   ARADDR;
  logic [7:0]    ARLEN;
  logic          ARVALID;
  logic          ARREADY;
  logic [63:0]   RDATA;
  logic          RVALID;
  logic          RLAST;
  logic          RREADY;
  logic          BUF_WREN;
  logic [63:0]   BUF_WDATA;
  logic [CW-1:0] BUF_WRCNT;

  modport master (
    output ARADDR, ARLEN, ARVALID, RREADY, BUF_WREN, BUF_WDATA,
    input  ARREADY, RDATA, RVALID, RLAST, BUF_WRCNT
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID, RREADY, BUF_WREN, BUF_WDATA,
    output ARREADY, RDATA, RVALID, RLAST, BUF_WRCNT
  );
endinterface

// File: rtl/disp_vramrd_ctrl.sv
// ---------------------------------------------------------------------------
// disp_vramrd_ctrl
//   Display VRAM read sequencer. On every VSYNC falling edge with DISPON=1 it
//   reads one full frame starting at DISPADDR as fixed-length 64-bit read
//   bursts and forwards each beat into the pixel FIFO. Only one burst is ever
//   outstanding and a burst is only requested when the FIFO has room for all
//   of it.
//
//   ACLK        clock
//   ARST_X      asynchronous active-low reset
//   DSP_VSYNC_X display VSYNC (active-low, asynchronous to ACLK)
//   DISPON      display enable, sampled at frame start and burst boundaries
//   DISPADDR    frame base address in 8-byte units, latched at frame start
//   FRM_BUSY    frame read in progress
//   bus         memory read port + FIFO write side (master modport)
// ---------------------------------------------------------------------------
module disp_vramrd_ctrl #(
  parameter int unsigned H_PIX      = 640,
  parameter int unsigned V_PIX      = 480,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic                      ACLK,
  input  logic                      ARST_X,
  input  logic                      DSP_VSYNC_X,
  input  logic                      DISPON,
  input  logic [28:0]               DISPADDR,
  output logic                      FRM_BUSY,
  disp_vramrd_ctrl_if.master        bus
);

  localparam int unsigned TOTAL_BEATS = H_PIX * V_PIX / 2;
  localparam int unsigned NBURST      = TOTAL_BEATS / BURST_LEN;
  localparam int unsigned STEP        = BURST_LEN * 8;
  localparam int unsigned BCW         = $clog2(NBURST + 1);
  localparam int unsigned BTW         = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic              vs_meta_q, vs_meta_d;
  logic              vs_sync_q, vs_sync_d;
  logic              vs_hist_q, vs_hist_d;
  logic [31:0]       base_q, base_d;
  logic [BCW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [BTW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [31:0]       araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              buf_wren_q, buf_wren_d;
  logic [63:0]       buf_wdata_q, buf_wdata_d;
  logic              frm_busy_q, frm_busy_d;

  logic              vs_fall;
  logic              fifo_room;
  logic              beat_take;

  // Falling edge of the synchronised VSYNC (active-low frame start).
  assign vs_fall = vs_hist_q & ~vs_sync_q;

  // Room for a whole burst: FIFO_DEPTH - BUF_WRCNT >= BURST_LEN, written so
  // that a (nonsensical) fill level above the depth never reads as room.
  assign fifo_room = (32'(bus.BUF_WRCNT) <= 32'(FIFO_DEPTH - BURST_LEN));

  assign beat_take = bus.RVALID & rready_q;

  always_comb begin
    state_d     = state_q;
    vs_meta_d   = DSP_VSYNC_X;
    vs_sync_d   = vs_meta_q;
    vs_hist_d   = vs_sync_q;
    base_d      = base_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    buf_wren_d  = 1'b0;
    buf_wdata_d = buf_wdata_q;
    frm_busy_d  = frm_busy_q;

    case (state_q)
      S_IDLE: begin
        frm_busy_d = 1'b0;
        if (vs_fall && DISPON) begin
          base_d      = {DISPADDR, 3'b000};
          burst_cnt_d = '0;
          frm_busy_d  = 1'b1;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (fifo_room) begin
          arvalid_d = 1'b1;
          // 32-bit add wraps naturally at the top of the address space.
          araddr_d  = base_q + 32'(burst_cnt_q) * 32'(STEP);
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        if (bus.ARREADY) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (beat_take) begin
          buf_wren_d  = 1'b1;
          buf_wdata_d = bus.RDATA;
          beat_cnt_d  = beat_cnt_q + 1'b1;
          // RLAST alone ends the burst, whatever the beat count says.
          if (bus.RLAST) begin
            rready_d    = 1'b0;
            burst_cnt_d = burst_cnt_q + 1'b1;
            if (burst_cnt_q == BCW'(NBURST - 1)) begin
              frm_busy_d = 1'b0;
              state_d    = S_IDLE;
            end else if (!DISPON) begin
              frm_busy_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              state_d    = S_WAIT;
            end
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        frm_busy_d = 1'b0;
      end
    endcase
  end

  // Sync flops reset to the idle (high) VSYNC level so that leaving reset
  // never fabricates a frame start.
  always_ff @(posedge ACLK or negedge ARST_X) begin
    if (!ARST_X) begin
      state_q     <= S_IDLE;
      vs_meta_q   <= 1'b1;
      vs_sync_q   <= 1'b1;
      vs_hist_q   <= 1'b1;
      base_q      <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      buf_wren_q  <= 1'b0;
      buf_wdata_q <= '0;
      frm_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_meta_q   <= vs_meta_d;
      vs_sync_q   <= vs_sync_d;
      vs_hist_q   <= vs_hist_d;
      base_q      <= base_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      buf_wren_q  <= buf_wren_d;
      buf_wdata_q <= buf_wdata_d;
      frm_busy_q  <= frm_busy_d;
    end
  end

  assign bus.ARADDR    = araddr_q;
  assign bus.ARLEN     = 8'(BURST_LEN - 1);
  assign bus.ARVALID   = arvalid_q;
  assign bus.RREADY    = rready_q;
  assign bus.BUF_WREN  = buf_wren_q;
  assign bus.BUF_WDATA = buf_wdata_q;
  assign FRM_BUSY      = frm_busy_q;

endmodule
